// File: rtl/res_deframer.sv
// Response-path deframer: pulls bytes from the response FIFO, hunts for 0xA5 frames and
// presents tag + 64-bit payload with valid/ready. Define RES_DEFRAMER_CSUM_EN to build the XOR checksum check.
module res_deframer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        almost_empty,
  output logic        rd_en,
  input  logic [7:0]  din,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_tag,
  output logic [63:0] rsp_data,
  output logic        rsp_err,
  output logic [7:0]  drop_cnt
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] HEADER = 8'hA5;

  typedef enum logic [2:0] {S_HUNT, S_TAG, S_DATA, S_CSUM, S_HOLD} state_t;

  state_t           state, state_nxt;
  logic             in_flight;
  logic [2:0]       idx;
  logic [CNT_W-1:0] idle_cnt;
  logic             in_frame;
  logic             timeout;

  assign in_frame  = (state == S_TAG) || (state == S_DATA) || (state == S_CSUM);
  // Abort on the TIMEOUT_CYCLES-th consecutive cycle with no byte sampled.
  assign timeout   = in_frame && !in_flight && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_valid = (state == S_HOLD);

  always_comb begin
    state_nxt = state;
    case (state)
      S_HUNT: if (in_flight && din == HEADER) state_nxt = S_TAG;
      S_TAG:  if (in_flight) state_nxt = S_DATA;
      S_DATA: if (in_flight && idx == 3'd7) state_nxt = S_CSUM;
      S_CSUM: if (in_flight) state_nxt = S_HOLD;
      S_HOLD: if (rsp_ready) state_nxt = S_HUNT;
      default: state_nxt = S_HUNT;
    endcase
    if (timeout) state_nxt = S_HUNT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HUNT;
      rd_en     <= 1'b0;
      in_flight <= 1'b0;
      idle_cnt  <= '0;
      drop_cnt  <= 8'h00;
    end else begin
      state     <= state_nxt;
      // One read outstanding at most: the cycle after a strobe is always the sample cycle.
      rd_en     <= !rd_en && (state_nxt != S_HOLD) && !almost_empty;
      in_flight <= rd_en;
      if (timeout || !in_frame || in_flight) idle_cnt <= '0;
      else                                   idle_cnt <= idle_cnt + 1'b1;
      if (timeout && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= 3'd0;
      rsp_tag  <= 8'h00;
      rsp_data <= 64'd0;
    end else if (in_flight) begin
      case (state)
        S_TAG: begin
          rsp_tag <= din;
          idx     <= 3'd0;
        end
        S_DATA: begin
          rsp_data[8*idx +: 8] <= din;
          idx                  <= idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef RES_DEFRAMER_CSUM_EN
  logic [7:0] csum_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_acc <= 8'h00;
      rsp_err  <= 1'b0;
    end else if (in_flight) begin
      case (state)
        S_TAG:   csum_acc <= din;
        S_DATA:  csum_acc <= csum_acc ^ din;
        S_CSUM:  rsp_err  <= (csum_acc != din);
        default: ;
      endcase
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: doc/res_deframer.md
# res_deframer

Response-path deframer between the response FIFO read port (clk domain) and the ROM front-end's response consumer. It pulls bytes from the FIFO one at a time and hunts for a frame header. It assembles one tagged 64-bit response per frame, optionally checks a checksum, and presents the result with a valid/ready handshake. Frame format: 0xA5 header, tag byte, 8 data bytes (little-endian), checksum byte.

## Interface
- TIMEOUT_CYCLES, 1024, idle cycles allowed between bytes inside a frame before the frame is abandoned (≥2)
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- almost_empty  input  1  FIFO read-side flag; no read is issued while high
- rd_en  output  1  FIFO read strobe, single-cycle pulse
- din  input  8  FIFO read data, valid the cycle after rd_en
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response
- rsp_tag  output  8  frame tag byte
- rsp_data  output  64  frame payload; byte 0 at [7:0]
- rsp_err  output  1  checksum mismatch on this response
- drop_cnt  output  8  saturating count of frames abandoned by timeout

## Operation
- States:
  - HUNT: looks for the header.
  - TAG: captures the tag.
  - DATA: captures 8 bytes, index 0..7.
  - CSUM: captures the checksum.
  - HOLD: presents the response.
- Byte fetch:
  - rd_en = 1 when state ≠ HOLD, almost_empty = 0 and no byte is in flight.
  - The in-flight flag is set the cycle after rd_en. din is sampled in that cycle, and the flag then clears.
  - At most one read is outstanding, so peak throughput is 1 byte per 2 clk.
- HUNT:
  - Sampled byte 0xA5 → TAG.
  - Any other byte is discarded and the block stays in HUNT.
- TAG: store byte in rsp_tag; clear checksum accumulator, then XOR byte in; → DATA, index 0.
- DATA:
  - Store byte at rsp_data[8*index +: 8] and XOR it into the accumulator.
  - At index 7 → CSUM.
- CSUM:
  - Compute the error as accumulator ≠ byte.
  - → HOLD.
- HOLD:
  - rsp_valid = 1. rsp_tag, rsp_data and rsp_err stay stable until rsp_valid && rsp_ready.
  - After the handshake → HUNT.
- Timeout:
  - In TAG/DATA/CSUM, an idle counter increments each cycle no byte is sampled. It clears on every sampled byte and on entering TAG.
  - When the count reaches TIMEOUT_CYCLES: → HUNT, drop_cnt += 1 (saturates at 255), and any partial data is discarded.
  - The counter does not run in HUNT or HOLD.
- Header bytes inside a frame (0xA5 in tag/data) are ordinary data; no resync occurs.

## Timing
- Reset values: rd_en 0, rsp_valid 0, rsp_tag 0x00, rsp_data 0, rsp_err 0, drop_cnt 0. State is HUNT with no byte in flight.
- Latency: checksum byte sampled in cycle t → rsp_valid = 1 in cycle t+1.
- Handshake completes in cycle h → rsp_valid = 0 in h+1. The earliest next rd_en is h+1.
- With rsp_ready held high, rsp_valid is a one-cycle pulse.
- rd_en is never asserted in HOLD. A read issued in the last cycle before a timeout abort is still sampled in HUNT.
- rsp_valid never depends combinationally on rsp_ready.
- rd_en is a registered output.
- Reset asserted mid-frame clears all state immediately. A byte read before reset is lost.

## Configuration
- RES_DEFRAMER_CSUM_EN defined:
  - Checksum = XOR of tag and 8 data bytes.
  - rsp_err = 1 on mismatch. The response is still delivered so the consumer can retry.
- Undefined:
  - The checksum byte is still read and consumed, but its value is ignored.
  - rsp_err is tied 0 and no accumulator logic is built.

## Test plan
- Reset: hold rst_n low with almost_empty = 0 → rd_en 0, rsp_valid 0, drop_cnt 0, all outputs 0 until after release.
- Good frame: A5 3C 01 02 03 04 05 06 07 08 34, rsp_ready = 1 → one rsp_valid pulse, rsp_tag 0x3C, rsp_data 0x0807060504030201, rsp_err 0. rsp_valid rises 1 cycle after the 0x34 byte is sampled.
- Garbage prefix: 00 FF 5A then the good frame → the three bytes are discarded and the identical response is produced. Exactly 14 rd_en pulses in total.
- Bad checksum: good frame with last byte 0x35 → rsp_err 1 with the macro defined, 0 without. Tag and data are unchanged.
- Backpressure: two good frames back-to-back, rsp_ready low for 20 cycles after the first rsp_valid → rd_en stays 0 and outputs stay stable throughout. After rsp_ready rises, the second frame (tag 0x3D) is delivered correctly.
- Timeout: TIMEOUT_CYCLES = 16; send A5 3C 01 02 03 04, then starve the FIFO for 30 cycles → state returns to HUNT and drop_cnt = 1 with no rsp_valid. A following good frame is decoded correctly.
